memory_responder: RTL and testbench

Word-addressed synchronous memory that services the Read/Write strobes driven by the CPU control unit. It latches the MAR address and MDR write data, inserts a configurable number of wait states, performs the access and returns read data with a one-cycle Ready pulse. It sits between the MAR/MDR datapath registers and the CPU's data bus, as the responding end of the control unit's memory strobes.

---
 rtl/memory_responder.sv | 176 +++++++++++++++++
 tb/tb_memory_responder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// memory_responder
//   Word-addressed synchronous memory that answers the control unit's
//   Read/Write strobes. A request is latched in IDLE, held for WAIT_CYCLES
//   wait states, performed on the closing edge of ACCESS, and acknowledged
//   with a one-cycle Ready pulse from DONE. RELEASE then waits for both
//   strobes to drop, so a held strobe cannot start a second access.
//
// Parameters
//   ADDR_W       word address width; depth is 2**ADDR_W words
//   DATA_W       word width
//   WAIT_CYCLES  wait states inserted before each access (0..15)
//
// Ports
//   Clock    in   rising-edge clock
//   Reset    in   asynchronous, active-high reset
//   Read     in   read strobe (level)
//   Write    in   write strobe (level)
//   Address  in   word address from MAR
//   DataIn   in   write data from MDR
//   DataOut  out  registered read data; holds until the next completed read
//   Ready    out  one-cycle pulse: access complete
//   Busy     out  high from request acceptance until back in IDLE
//   Error    out  one-cycle pulse: Read and Write both high in IDLE
module memory_responder #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              Ready,
  output logic              Busy,
  output logic              Error
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE,
    S_RELEASE
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                op_write_q, op_write_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                error_q, error_d;
  logic                mem_we;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                strobes_low;
  assign strobes_low = !Read && !Write;

  // Next-state and next-output logic. Ready, Busy and Error are computed
  // from the next state so that the registered outputs line up with the
  // state they describe.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    op_write_d = op_write_q;
    dout_d     = dout_q;
    ready_d    = 1'b0;
    error_d    = 1'b0;
    mem_we     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (Read ^ Write) begin
          addr_d     = Address;
          data_d     = DataIn;
          op_write_d = Write;
          if (WAIT_CYCLES == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end else if (Read && Write) begin
          error_d = 1'b1;
        end
      end

      // The counter is loaded with WAIT_CYCLES, so the edge that takes it
      // to zero is the one where it currently reads one.
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        state_d = S_DONE;
        ready_d = 1'b1;
        if (op_write_q) begin
          mem_we = 1'b1;
        end else begin
          dout_d = mem[addr_q];
        end
      end

      S_DONE: begin
        state_d = strobes_low ? S_IDLE : S_RELEASE;
      end

      S_RELEASE: begin
        if (strobes_low) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      op_write_q <= 1'b0;
      dout_q     <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      op_write_q <= op_write_d;
      dout_q     <= dout_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
    end
  end

  // NOTE: the array has no reset; clearing a RAM would need a write per word
  // and prevents mapping onto memory macros. A reset during WAIT or ACCESS
  // forces IDLE before the write edge, so mem_we never fires for it.
  always_ff @(posedge Clock) begin
    if (mem_we) begin
      mem[addr_q] <= data_q;
    end
  end

  assign DataOut = dout_q;
  assign Ready   = ready_q;
  assign Busy    = busy_q;
  assign Error   = error_q;

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder
//   Drives three responders (WAIT_CYCLES = 0, 1, 3) from one set of strobes.
//   Each transaction waits until all three are idle again, so their memories
//   stay identical and one expected-value model serves all of them.
//   Index 1 (WAIT_CYCLES = 1) is the default configuration.
module tb_memory_responder;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Read;
  logic        Write;
  logic [8:0]  Address;
  logic [31:0] DataIn;

  logic [31:0] dout  [3];
  logic        ready [3];
  logic        busy  [3];
  logic        err   [3];

  int          checks = 0;
  int          errors = 0;

  // Per-transaction observations filled in by access().
  int          rdy_idx [3];
  int          rdy_cnt [3];
  logic [31:0] rd_data [3];
  int          busy_off;

  logic [31:0] exp_dout;

  always #5 Clock = ~Clock;

  memory_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(0)) u_dut_w0 (
    .Clock(Clock), .Reset(Reset), .Read(Read), .Write(Write),
    .Address(Address), .DataIn(DataIn),
    .DataOut(dout[0]), .Ready(ready[0]), .Busy(busy[0]), .Error(err[0])
  );

  memory_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(1)) u_dut_w1 (
    .Clock(Clock), .Reset(Reset), .Read(Read), .Write(Write),
    .Address(Address), .DataIn(DataIn),
    .DataOut(dout[1]), .Ready(ready[1]), .Busy(busy[1]), .Error(err[1])
  );

  memory_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(3)) u_dut_w3 (
    .Clock(Clock), .Reset(Reset), .Read(Read), .Write(Write),
    .Address(Address), .DataIn(DataIn),
    .DataOut(dout[2]), .Ready(ready[2]), .Busy(busy[2]), .Error(err[2])
  );

  function automatic int wc(input int k);
    case (k)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  // Issue one request and follow it until every responder is idle again.
  // Edge index 0 is the acceptance edge E0. The strobe is held for at least
  // 'hold' edges and until all three responders have pulsed Ready. With
  // 'scramble' set, Address and DataIn are inverted right after E0.
  task automatic access(input logic wr, input logic [8:0] a,
                        input logic [31:0] d, input int hold,
                        input bit scramble);
    bit dropped = 1'b0;
    bit done    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rdy_idx[k] = -1;
      rdy_cnt[k] = 0;
      rd_data[k] = 'x;
    end
    busy_off = -1;
    @(negedge Clock);
    Read    = !wr;
    Write   = wr;
    Address = a;
    DataIn  = d;
    for (int idx = 0; idx < 40 && !done; idx++) begin
      @(posedge Clock);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (ready[k] === 1'b1) begin
          if (rdy_idx[k] < 0) rdy_idx[k] = idx;
          rdy_cnt[k]++;
          rd_data[k] = dout[k];
        end
      end
      if (idx > 0 && busy[1] === 1'b0 && busy_off < 0) busy_off = idx;
      if (dropped && busy[0] === 1'b0 && busy[1] === 1'b0 && busy[2] === 1'b0) begin
        done = 1'b1;
      end else begin
        @(negedge Clock);
        if (scramble && idx == 0) begin
          Address = ~a;
          DataIn  = ~d;
        end
        if (!dropped && idx >= hold - 1 &&
            rdy_idx[0] >= 0 && rdy_idx[1] >= 0 && rdy_idx[2] >= 0) begin
          Read    = 1'b0;
          Write   = 1'b0;
          dropped = 1'b1;
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL access_timeout addr=%h actual=still_busy required=idle", a);
      Read  = 1'b0;
      Write = 1'b0;
    end
  endtask

  task automatic test_reset();
    Reset   = 1'b1;
    Read    = 1'b0;
    Write   = 1'b0;
    Address = '0;
    DataIn  = '0;
    repeat (2) @(posedge Clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({dout[k], ready[k], busy[k], err[k]} !== 35'd0) begin
        errors++;
        $display("FAIL reset_values dut=%0d actual=%h/%b/%b/%b required=0/0/0/0",
                 k, dout[k], ready[k], busy[k], err[k]);
      end
    end
    @(negedge Clock);
    Reset    = 1'b0;
    exp_dout = 32'h0;

    // Known content at 0x010, then abort a write to it from WAIT.
    access(1'b1, 9'h010, 32'h0000_0000, 1, 1'b0);
    @(negedge Clock);
    Write   = 1'b1;
    Address = 9'h010;
    DataIn  = 32'hDEAD_BEEF;
    @(posedge Clock);
    #1;
    checks++;
    if (busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL abort_accepted actual=%b required=1", busy[1]);
    end
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({dout[k], ready[k], busy[k], err[k]} !== 35'd0) begin
        errors++;
        $display("FAIL abort_outputs dut=%0d actual=%h/%b/%b/%b required=0/0/0/0",
                 k, dout[k], ready[k], busy[k], err[k]);
      end
    end
    @(negedge Clock);
    Write = 1'b0;
    Reset = 1'b0;

    access(1'b0, 9'h010, 32'h0, 1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdy_cnt[k] !== 1 || rd_data[k] !== 32'h0000_0000) begin
        errors++;
        $display("FAIL abort_no_write dut=%0d actual=%0d/%h required=1/00000000",
                 k, rdy_cnt[k], rd_data[k]);
      end
    end
  endtask

  task automatic test_write_read();
    access(1'b1, 9'h005, 32'h1234_5678, 1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdy_cnt[k] !== 1 || rdy_idx[k] !== wc(k) + 1 || rd_data[k] !== exp_dout) begin
        errors++;
        $display("FAIL write_ready dut=%0d actual=cnt%0d/idx%0d/%h required=cnt1/idx%0d/%h",
                 k, rdy_cnt[k], rdy_idx[k], rd_data[k], wc(k) + 1, exp_dout);
      end
    end
    access(1'b0, 9'h005, 32'h0, 1, 1'b0);
    exp_dout = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdy_cnt[k] !== 1 || rdy_idx[k] !== wc(k) + 1 || rd_data[k] !== exp_dout) begin
        errors++;
        $display("FAIL read_back dut=%0d actual=cnt%0d/idx%0d/%h required=cnt1/idx%0d/%h",
                 k, rdy_cnt[k], rdy_idx[k], rd_data[k], wc(k) + 1, exp_dout);
      end
    end
  endtask

  task automatic test_held_strobe();
    // Read held for edges E0..E7; it is seen low at E8, where Busy drops.
    access(1'b0, 9'h005, 32'h0, 8, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdy_cnt[k] !== 1 || rd_data[k] !== 32'h1234_5678) begin
        errors++;
        $display("FAIL held_single_ready dut=%0d actual=cnt%0d/%h required=cnt1/12345678",
                 k, rdy_cnt[k], rd_data[k]);
      end
    end
    checks++;
    if (busy_off !== 8) begin
      errors++;
      $display("FAIL held_busy_release actual=%0d required=8", busy_off);
    end
  endtask

  task automatic test_conflict();
    access(1'b1, 9'h001, 32'h1111_1111, 1, 1'b0);
    @(negedge Clock);
    Read    = 1'b1;
    Write   = 1'b1;
    Address = 9'h001;
    DataIn  = 32'h2222_2222;
    @(posedge Clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (err[k] !== 1'b1 || ready[k] !== 1'b0 || busy[k] !== 1'b0) begin
        errors++;
        $display("FAIL conflict_error dut=%0d actual=e%b/r%b/b%b required=e1/r0/b0",
                 k, err[k], ready[k], busy[k]);
      end
    end
    @(negedge Clock);
    Read  = 1'b0;
    Write = 1'b0;
    @(posedge Clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (err[k] !== 1'b0 || ready[k] !== 1'b0 || busy[k] !== 1'b0) begin
        errors++;
        $display("FAIL conflict_pulse_end dut=%0d actual=e%b/r%b/b%b required=e0/r0/b0",
                 k, err[k], ready[k], busy[k]);
      end
    end
    access(1'b0, 9'h001, 32'h0, 1, 1'b0);
    exp_dout = 32'h1111_1111;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rd_data[k] !== exp_dout) begin
        errors++;
        $display("FAIL conflict_mem_unchanged dut=%0d actual=%h required=%h",
                 k, rd_data[k], exp_dout);
      end
    end
  endtask

  task automatic test_boundaries();
    access(1'b1, 9'h1FF, 32'hFFFF_FFFF, 1, 1'b0);
    access(1'b1, 9'h000, 32'hA5A5_A5A5, 1, 1'b0);
    access(1'b0, 9'h1FF, 32'h0, 1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rd_data[k] !== 32'hFFFF_FFFF) begin
        errors++;
        $display("FAIL boundary_top dut=%0d actual=%h required=ffffffff", k, rd_data[k]);
      end
    end
    access(1'b0, 9'h000, 32'h0, 1, 1'b0);
    exp_dout = 32'hA5A5_A5A5;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rd_data[k] !== exp_dout) begin
        errors++;
        $display("FAIL boundary_bottom dut=%0d actual=%h required=%h", k, rd_data[k], exp_dout);
      end
    end
  endtask

  task automatic test_latency_sweep();
    // Address and data are inverted right after acceptance; the latched
    // values must be the ones used.
    access(1'b1, 9'h0AA, 32'hCAFE_F00D, 1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdy_idx[k] !== wc(k) + 1 || rd_data[k] !== exp_dout) begin
        errors++;
        $display("FAIL latency_write dut=%0d actual=idx%0d/%h required=idx%0d/%h",
                 k, rdy_idx[k], rd_data[k], wc(k) + 1, exp_dout);
      end
    end
    access(1'b0, 9'h0AA, 32'h0, 1, 1'b1);
    exp_dout = 32'hCAFE_F00D;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdy_idx[k] !== wc(k) + 1 || rd_data[k] !== exp_dout) begin
        errors++;
        $display("FAIL latency_read dut=%0d actual=idx%0d/%h required=idx%0d/%h",
                 k, rdy_idx[k], rd_data[k], wc(k) + 1, exp_dout);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_held_strobe();
    test_conflict();
    test_boundaries();
    test_latency_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
